// File: rtl/fb_painter.sv
// rtl/fb_painter.sv - double-buffered 64x64 framebuffer painter with PWM readout for an LED panel driver
module fb_painter #(
    parameter int BPC = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [12:0]      frame,
    input  logic [7:0]       subframe,
    input  logic [5:0]       x,
    input  logic [5:0]       y0,
    input  logic [5:0]       y1,
    output logic [2:0]       rgb0,
    output logic [2:0]       rgb1,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [5:0]       wr_x,
    input  logic [5:0]       wr_y,
    input  logic [3*BPC-1:0] wr_rgb,
    input  logic             swap_req,
    output logic             swap_done
);

    localparam int PW = 3 * BPC;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_PEND  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [10:0] clr_addr, clr_addr_nx;
    logic        front, front_nx;
    logic        pending, pending_nx;
    logic        swap_done_nx;
    logic [12:0] prev_frame;
    logic        frame_edge;

    // RAM index is {bank, half}; half 0 holds rows 0..31, half 1 rows 32..63
    logic [PW-1:0] mem [4][2048];
    logic [3:0]    ram_we;
    logic [10:0]   ram_addr;
    logic [PW-1:0] ram_wdata;

    logic [PW-1:0] rd_pix0, rd_pix1;
    logic [BPC-1:0] phase;
    logic          unused_bits;

    assign frame_edge  = (frame != prev_frame);
    assign phase       = subframe[BPC-1:0];
    assign unused_bits = &{1'b0, subframe, y0[5], y1[5]};

    // channel is lit while its intensity exceeds the PWM phase; output order is {B,G,R}
    function automatic logic [2:0] pwm(input logic [PW-1:0] pix, input logic [BPC-1:0] ph);
        pwm = {pix[BPC-1:0] > ph, pix[2*BPC-1:BPC] > ph, pix[3*BPC-1:2*BPC] > ph};
    endfunction

    // next-state, write-port steering and handshake outputs
    always_comb begin
        state_nx     = state;
        clr_addr_nx  = clr_addr;
        front_nx     = front;
        pending_nx   = pending;
        swap_done_nx = 1'b0;
        wr_ready     = 1'b0;
        ram_we       = 4'b0000;
        ram_addr     = {wr_y[4:0], wr_x};
        ram_wdata    = wr_rgb;
        case (state)
            S_CLEAR: begin
                ram_we      = 4'b1111;
                ram_addr    = clr_addr;
                ram_wdata   = '0;
                clr_addr_nx = clr_addr + 11'd1;
                if (swap_req) begin
                    pending_nx = 1'b1;
                end
                if (clr_addr == 11'd2047) begin
                    clr_addr_nx = 11'd0;
                    pending_nx  = 1'b0;
                    // a request arriving on the final clear cycle is honoured as well
                    state_nx    = (pending || swap_req) ? S_PEND : S_IDLE;
                end
            end
            S_IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    ram_we[{~front, wr_y[5]}] = 1'b1;
                end
                if (swap_req) begin
                    state_nx = S_PEND;
                end
            end
            S_PEND: begin
                if (frame_edge) begin
                    front_nx     = ~front;
                    swap_done_nx = 1'b1;
                    state_nx     = S_IDLE;
                end
            end
            default: begin
                state_nx = S_CLEAR;
            end
        endcase
    end

    // control state register; frame history tracks the driver every cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_CLEAR;
            clr_addr   <= 11'd0;
            front      <= 1'b0;
            pending    <= 1'b0;
            swap_done  <= 1'b0;
            prev_frame <= 13'd0;
        end else begin
            state      <= state_nx;
            clr_addr   <= clr_addr_nx;
            front      <= front_nx;
            pending    <= pending_nx;
            swap_done  <= swap_done_nx;
            prev_frame <= frame;
        end
    end

    // pixel storage; contents survive reset and are wiped by the clear sweep
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) begin
                mem[i][ram_addr] <= ram_wdata;
            end
        end
    end

    assign rd_pix0 = mem[{front, 1'b0}][{y0[4:0], x}];
    assign rd_pix1 = mem[{front, 1'b1}][{y1[4:0], x}];

    // registered PWM readout of the front bank; blanked while the clear sweep runs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb0 <= 3'b000;
            rgb1 <= 3'b000;
        end else if (state == S_CLEAR) begin
            rgb0 <= 3'b000;
            rgb1 <= 3'b000;
        end else begin
            rgb0 <= pwm(rd_pix0, phase);
            rgb1 <= pwm(rd_pix1, phase);
        end
    end

endmodule

// File: tb/tb_fb_painter.sv
// tb/tb_fb_painter.sv - directed self-checking bench for fb_painter
module tb_fb_painter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x, y0, y1;
    logic [2:0]  rgb0, rgb1;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_x, wr_y;
    logic [11:0] wr_rgb;
    logic        swap_req;
    logic        swap_done;

    int total = 0;
    int passes = 0;

    fb_painter #(.BPC(4)) dut (
        .clk(clk), .resetn(resetn), .frame(frame), .subframe(subframe),
        .x(x), .y0(y0), .y1(y1), .rgb0(rgb0), .rgb1(rgb1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_rgb(wr_rgb), .swap_req(swap_req), .swap_done(swap_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // advance one clock; drive and sample 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // count cycles until wr_ready rises, watching rgb and swap_done on the way
    task automatic wait_ready(output int n, output int rgb_on, output int swaps);
        n = 0; rgb_on = 0; swaps = 0;
        while (n < 3000) begin
            step();
            n = n + 1;
            if (rgb0 != 3'b000 || rgb1 != 3'b000) rgb_on = rgb_on + 1;
            if (swap_done) swaps = swaps + 1;
            if (wr_ready) break;
        end
    endtask

    task automatic write_px(input logic [5:0] px, input logic [5:0] py, input logic [11:0] val);
        chk("wr_ready_before_write", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1; wr_x = px; wr_y = py; wr_rgb = val;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_swap(input string tag);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk({tag, "_pend_ready"}, {31'd0, wr_ready}, 32'd0);
        chk({tag, "_pend_nodone"}, {31'd0, swap_done}, 32'd0);
        frame = frame + 13'd1;
        step();
        chk({tag, "_done"}, {31'd0, swap_done}, 32'd1);
        step();
        chk({tag, "_done_clear"}, {31'd0, swap_done}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, wr_ready}, 32'd1);
    endtask

    task automatic read_px(input logic [5:0] px, input logic [5:0] r0, input logic [5:0] r1,
                           input logic [7:0] sf);
        x = px; y0 = r0; y1 = r1; subframe = sf;
        step();
    endtask

    initial begin
        int n, rgb_on, swaps, cnt_ready, cnt_done;
        resetn = 1'b0; frame = 13'd0; subframe = 8'd0;
        x = 6'd5; y0 = 6'd3; y1 = 6'd35;
        wr_valid = 1'b0; wr_x = 6'd0; wr_y = 6'd0; wr_rgb = 12'h000; swap_req = 1'b0;

        // 1: reset values, then 2048-cycle clear with blanked output
        step(); step();
        chk("rst_rgb0", {29'd0, rgb0}, 32'd0);
        chk("rst_rgb1", {29'd0, rgb1}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_swap_done", {31'd0, swap_done}, 32'd0);
        resetn = 1'b1;
        wait_ready(n, rgb_on, swaps);
        chk("clear_len", n, 32'd2048);
        chk("clear_rgb_blank", rgb_on, 32'd0);
        chk("clear_no_swap", swaps, 32'd0);

        // frame edge while idle must not swap
        frame = frame + 13'd1;
        step();
        chk("idle_edge_no_swap", {31'd0, swap_done}, 32'd0);

        // 2: red top pixel, blue bottom pixel, swap and read back
        write_px(6'd5, 6'd3, 12'hF00);
        write_px(6'd5, 6'd35, 12'h00F);
        do_swap("swap1");
        read_px(6'd5, 6'd3, 6'd35, 8'd7);
        chk("t2_rgb0", {29'd0, rgb0}, 32'b001);
        chk("t2_rgb1", {29'd0, rgb1}, 32'b100);

        // 3: R=4 in bank0 at (10,7); PWM sweep of all 16 phases
        write_px(6'd10, 6'd7, 12'h400);
        do_swap("swap2");
        for (int s = 0; s < 16; s++) begin
            read_px(6'd10, 6'd7, 6'd39, s[7:0]);
            chk($sformatf("pwm_r_sf%0d", s), {29'd0, rgb0}, (s < 4) ? 32'b001 : 32'b000);
        end
        chk("pwm_bottom_dark", {29'd0, rgb1}, 32'd0);
        read_px(6'd5, 6'd3, 6'd35, 8'd0);
        chk("bank0_cleared", {29'd0, rgb0}, 32'd0);

        // 4: long pending with a second ignored request, then one frame edge
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        cnt_ready = 0; cnt_done = 0;
        for (int i = 0; i < 1000; i++) begin
            swap_req = (i == 500);
            step();
            if (wr_ready) cnt_ready = cnt_ready + 1;
            if (swap_done) cnt_done = cnt_done + 1;
        end
        swap_req = 1'b0;
        chk("pend_hold_ready", cnt_ready, 32'd0);
        chk("pend_hold_done", cnt_done, 32'd0);
        frame = frame + 13'd1;
        step();
        chk("pend_edge_done", {31'd0, swap_done}, 32'd1);
        step();
        chk("pend_edge_once", {31'd0, swap_done}, 32'd0);
        chk("pend_ready_after", {31'd0, wr_ready}, 32'd1);
        read_px(6'd5, 6'd3, 6'd35, 8'd0);
        chk("t4_front_bank1", {29'd0, rgb0}, 32'b001);

        // 5: swap request during clear goes pending after the sweep
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        cnt_ready = 0; cnt_done = 0;
        for (int i = 0; i < 2100; i++) begin
            swap_req = (i == 100);
            step();
            if (wr_ready) cnt_ready = cnt_ready + 1;
            if (swap_done) cnt_done = cnt_done + 1;
        end
        swap_req = 1'b0;
        chk("clr_req_ready", cnt_ready, 32'd0);
        chk("clr_req_done", cnt_done, 32'd0);
        frame = frame + 13'd1;
        step();
        chk("clr_req_swap", {31'd0, swap_done}, 32'd1);
        step();
        chk("clr_req_ready_after", {31'd0, wr_ready}, 32'd1);

        // 6: reset while pending drops the request and restores bank0 as front
        write_px(6'd5, 6'd3, 12'hF00);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("t6_pending", {31'd0, wr_ready}, 32'd0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        frame = frame + 13'd1;
        wait_ready(n, rgb_on, swaps);
        chk("t6_clear_len", n, 32'd2048);
        chk("t6_no_swap", swaps, 32'd0);
        write_px(6'd5, 6'd3, 12'hF00);
        read_px(6'd5, 6'd3, 6'd35, 8'd0);
        chk("t6_front_bank0", {29'd0, rgb0}, 32'd0);
        do_swap("swap6");
        read_px(6'd5, 6'd3, 6'd35, 8'd0);
        chk("t6_after_swap", {29'd0, rgb0}, 32'b001);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
